// File: rtl/layer_ctrl_pkg.sv
// Shared state encoding and width helpers for the convolution-layer stream controller
// and its position counter.
package layer_ctrl_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDrain,
      StDone
   } ctrl_state_e;

   // Width of a row/column index for a square frame of the given size.
   function automatic int unsigned pos_width(input int unsigned size);
      return (size > 1) ? $clog2(size) : 1;
   endfunction

   // Width able to hold every value 0..max_val inclusive.
   function automatic int unsigned count_width(input int unsigned max_val);
      return (max_val > 0) ? $clog2(max_val + 1) : 1;
   endfunction

   function automatic int unsigned in_count_width(input int unsigned size);
      return count_width(size * size);
   endfunction

   function automatic int unsigned timer_width(input int unsigned timeout);
      return count_width(timeout);
   endfunction

endpackage

// File: rtl/pixel_pos_counter.sv
// Raster-order row/column tracker: column wraps at ImgSize and carries into the row.
// The row is left free-running so a frame end does not disturb the last reported value.
module pixel_pos_counter
   import layer_ctrl_pkg::*;
#(
   parameter int unsigned ImgSize = 104
) (
   input  logic                            clk_i,
   input  logic                            rst_i,
   input  logic                            clr_i,
   input  logic                            en_i,
   output logic [pos_width(ImgSize)-1:0]   row_o,
   output logic [pos_width(ImgSize)-1:0]   col_o
);

   localparam int unsigned PosW = pos_width(ImgSize);
   localparam logic [PosW-1:0] ColLast = PosW'(ImgSize - 1);

   logic [PosW-1:0] row_q, row_d;
   logic [PosW-1:0] col_q, col_d;

   always_comb begin
      row_d = row_q;
      col_d = col_q;
      if (clr_i) begin
         row_d = '0;
         col_d = '0;
      end else if (en_i) begin
         if (col_q == ColLast) begin
            col_d = '0;
            row_d = row_q + 1'b1;
         end else begin
            col_d = col_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         row_q <= '0;
         col_q <= '0;
      end else begin
         row_q <= row_d;
         col_q <= col_d;
      end
   end

   assign row_o = row_q;
   assign col_o = col_q;

endmodule

// File: rtl/conv_layer_stream_ctrl.sv
// Frame sequencer for a conv-layer bank: pulls one IMG_SIZE x IMG_SIZE frame into the
// bank, then waits for all bank outputs to arrive or for the drain idle timer to expire.
module conv_layer_stream_ctrl
   import layer_ctrl_pkg::*;
#(
   parameter int unsigned DATA_IN_WIDTH = 1024,
   parameter int unsigned IMG_SIZE      = 104,
   parameter int unsigned OUT_PIXELS    = 10816,
   parameter int unsigned DRAIN_TIMEOUT = 4096
) (
   input  logic                                 Clk,
   input  logic                                 Rst,
   input  logic                                 start,
   input  logic [DATA_IN_WIDTH-1:0]             src_data,
   input  logic                                 src_valid,
   output logic                                 src_ready,
   input  logic                                 sink_afull,
   output logic [DATA_IN_WIDTH-1:0]             fm_data_in,
   output logic                                 fm_valid_in,
   output logic [pos_width(IMG_SIZE)-1:0]       fm_row,
   output logic [pos_width(IMG_SIZE)-1:0]       fm_col,
   input  logic                                 fm_valid_out,
   output logic                                 busy,
   output logic                                 done,
   output logic                                 timeout_err,
   output logic [count_width(OUT_PIXELS)-1:0]   out_count
);

   localparam int unsigned PosW = pos_width(IMG_SIZE);
   localparam int unsigned InW  = in_count_width(IMG_SIZE);
   localparam int unsigned CntW = count_width(OUT_PIXELS);
   localparam int unsigned TmrW = timer_width(DRAIN_TIMEOUT);

   localparam logic [InW-1:0]  FramePixels = InW'(IMG_SIZE * IMG_SIZE);
   localparam logic [CntW-1:0] OutMax      = CntW'(OUT_PIXELS);
   localparam logic [TmrW-1:0] TimerLast   = TmrW'(DRAIN_TIMEOUT - 1);

   ctrl_state_e state_q, state_d;

   logic [InW-1:0]  in_count_q, in_count_d;
   logic [CntW-1:0] out_count_q, out_count_d;
   logic [TmrW-1:0] timer_q, timer_d;
   logic            timeout_err_q, timeout_err_d;

   logic [DATA_IN_WIDTH-1:0] fm_data_q;
   logic                     fm_valid_q;
   logic [PosW-1:0]          fm_row_q, fm_col_q;

   logic            accept;
   logic            count_phase;
   logic            pos_clr;
   logic [PosW-1:0] pos_row, pos_col;

   assign src_ready   = (state_q == StRun) && !sink_afull && (in_count_q < FramePixels);
   assign accept      = src_valid && src_ready;
   assign count_phase = (state_q == StRun) || (state_q == StDrain);

   pixel_pos_counter #(
      .ImgSize (IMG_SIZE)
   ) u_pos (
      .clk_i (Clk),
      .rst_i (Rst),
      .clr_i (pos_clr),
      .en_i  (accept),
      .row_o (pos_row),
      .col_o (pos_col)
   );

   always_comb begin
      state_d       = state_q;
      in_count_d    = in_count_q;
      out_count_d   = out_count_q;
      timer_d       = timer_q;
      timeout_err_d = timeout_err_q;
      pos_clr       = 1'b0;

      if (count_phase && fm_valid_out && (out_count_q != OutMax)) begin
         out_count_d = out_count_q + 1'b1;
      end

      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d       = StRun;
               in_count_d    = '0;
               out_count_d   = '0;
               timer_d       = '0;
               timeout_err_d = 1'b0;
               pos_clr       = 1'b1;
            end
         end
         StRun: begin
            if (accept) begin
               in_count_d = in_count_q + 1'b1;
               if (in_count_d == FramePixels) begin
                  state_d = StDrain;
               end
            end
         end
         StDrain: begin
            timer_d = fm_valid_out ? '0 : timer_q + 1'b1;
            // Completion wins over expiry; an output on the expiry cycle is progress.
            if (out_count_d == OutMax) begin
               state_d = StDone;
            end else if (!fm_valid_out && (timer_q == TimerLast)) begin
               timeout_err_d = 1'b1;
               state_d       = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q       <= StIdle;
         in_count_q    <= '0;
         out_count_q   <= '0;
         timer_q       <= '0;
         timeout_err_q <= 1'b0;
         fm_valid_q    <= 1'b0;
         fm_data_q     <= '0;
         fm_row_q      <= '0;
         fm_col_q      <= '0;
      end else begin
         state_q       <= state_d;
         in_count_q    <= in_count_d;
         out_count_q   <= out_count_d;
         timer_q       <= timer_d;
         timeout_err_q <= timeout_err_d;
         fm_valid_q    <= accept;
         if (accept) begin
            fm_data_q <= src_data;
            fm_row_q  <= pos_row;
            fm_col_q  <= pos_col;
         end
      end
   end

   assign fm_data_in  = fm_data_q;
   assign fm_valid_in = fm_valid_q;
   assign fm_row      = fm_row_q;
   assign fm_col      = fm_col_q;
   assign busy        = count_phase;
   assign done        = (state_q == StDone);
   assign timeout_err = timeout_err_q;
   assign out_count   = out_count_q;

endmodule

// File: tb/tb_conv_layer_stream_ctrl.sv
// Scenario bench for conv_layer_stream_ctrl on a 4x4 frame with an 8-cycle drain timeout.
module tb_conv_layer_stream_ctrl;

   localparam int unsigned DW   = 32;
   localparam int unsigned IMG  = 4;
   localparam int unsigned OUTP = 16;
   localparam int unsigned TMO  = 8;
   localparam int          NPIX = IMG * IMG;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [DW-1:0] src_data;
   logic          src_valid;
   logic          src_ready;
   logic          sink_afull;
   logic [DW-1:0] fm_data_in;
   logic          fm_valid_in;
   logic [1:0]    fm_row;
   logic [1:0]    fm_col;
   logic          fm_valid_out;
   logic          busy;
   logic          done;
   logic          timeout_err;
   logic [4:0]    out_count;

   int checks = 0;
   int errors = 0;

   logic [DW+3:0] exp_q[$];
   logic [2:0]    bank_pipe;
   int            bank_seen;
   int            fwd_cnt, done_cnt, done_cyc, last_vo_cyc, to_cyc, out_at_done, pushed;

   always #5 clk = ~clk;

   conv_layer_stream_ctrl #(
      .DATA_IN_WIDTH (DW),
      .IMG_SIZE      (IMG),
      .OUT_PIXELS    (OUTP),
      .DRAIN_TIMEOUT (TMO)
   ) dut (
      .Clk          (clk),
      .Rst          (rst),
      .start        (start),
      .src_data     (src_data),
      .src_valid    (src_valid),
      .src_ready    (src_ready),
      .sink_afull   (sink_afull),
      .fm_data_in   (fm_data_in),
      .fm_valid_in  (fm_valid_in),
      .fm_row       (fm_row),
      .fm_col       (fm_col),
      .fm_valid_out (fm_valid_out),
      .busy         (busy),
      .done         (done),
      .timeout_err  (timeout_err),
      .out_count    (out_count)
   );

   // One frame: source at valid_pct, optional 5-cycle afull window, bank model that
   // returns the first `keep` pixels 3 cycles later, optional stray start at stray_at.
   task automatic run_frame(input int valid_pct, input int afull_at, input int keep,
                            input int stray_at);
      int            exp_row;
      int            exp_col;
      logic [DW+3:0] exp;
      exp_row = 0; exp_col = 0;
      fwd_cnt = 0; done_cnt = 0; done_cyc = -1; last_vo_cyc = -1; to_cyc = -1;
      out_at_done = -1; pushed = 0; bank_pipe = '0; bank_seen = 0;
      exp_q.delete();
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         if (k > 0) begin
            if (fm_valid_in === 1'b1) begin
               fwd_cnt++;
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL fwd_extra: fm_valid_in at cycle %0d, expected no pixel", k);
               end else begin
                  exp = exp_q.pop_front();
                  if ({fm_data_in, fm_row, fm_col} !== exp) begin
                     errors++;
                     $display("FAIL fwd_pixel: got data=%h row=%0d col=%0d, expected data=%h row=%0d col=%0d",
                              fm_data_in, fm_row, fm_col, exp[DW+3:4], exp[3:2], exp[1:0]);
                  end
               end
            end
            if (afull_at >= 0 && k > afull_at && k <= afull_at + 5) begin
               checks++;
               if (fm_valid_in !== 1'b0) begin
                  errors++;
                  $display("FAIL afull_no_fwd: cycle %0d fm_valid_in=%b, expected 0", k, fm_valid_in);
               end
            end
            if (k == 1) begin
               checks++;
               if (busy !== 1'b1 || timeout_err !== 1'b0) begin
                  errors++;
                  $display("FAIL start_accept: busy=%b timeout_err=%b, expected 1/0", busy, timeout_err);
               end
            end
            if (timeout_err === 1'b1 && to_cyc < 0) to_cyc = k;
            if (done === 1'b1) begin
               done_cnt++;
               if (done_cyc < 0) begin
                  done_cyc = k;
                  out_at_done = int'(out_count);
                  checks++;
                  if (busy !== 1'b0) begin
                     errors++;
                     $display("FAIL busy_in_done: busy=%b, expected 0", busy);
                  end
               end
            end
            if (done_cyc >= 0 && k >= done_cyc + 4) break;
         end
         start      = (k == 0) || (k == stray_at);
         sink_afull = (afull_at >= 0 && k >= afull_at && k < afull_at + 5);
         src_valid  = ($urandom_range(99) < valid_pct);
         src_data   = $urandom;
         if (fm_valid_in === 1'b1) begin
            bank_pipe = {bank_pipe[1:0], (bank_seen < keep)};
            bank_seen++;
         end else begin
            bank_pipe = {bank_pipe[1:0], 1'b0};
         end
         fm_valid_out = bank_pipe[2];
         if (fm_valid_out) last_vo_cyc = k + 1;
         #1;
         if (sink_afull) begin
            checks++;
            if (src_ready !== 1'b0) begin
               errors++;
               $display("FAIL afull_ready: cycle %0d src_ready=%b, expected 0", k, src_ready);
            end
         end
         if (pushed >= NPIX && src_valid) begin
            checks++;
            if (src_ready !== 1'b0) begin
               errors++;
               $display("FAIL ready_after_frame: src_ready=%b, expected 0", src_ready);
            end
         end
         if (src_valid && src_ready === 1'b1) begin
            exp_q.push_back({src_data, 2'(exp_row), 2'(exp_col)});
            pushed++;
            if (exp_col == IMG - 1) begin
               exp_col = 0;
               exp_row++;
            end else begin
               exp_col++;
            end
         end
      end
      start = 1'b0; src_valid = 1'b0; sink_afull = 1'b0; fm_valid_out = 1'b0;
      checks++;
      if (done_cyc < 0) begin
         errors++;
         $display("FAIL frame_bound: no done within cycle budget, expected done");
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || fm_valid_in !== 1'b0 || src_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctrl: busy=%b done=%b fm_valid_in=%b src_ready=%b, expected 0",
                  busy, done, fm_valid_in, src_ready);
      end
      checks++;
      if (fm_data_in !== '0 || fm_row !== '0 || fm_col !== '0) begin
         errors++;
         $display("FAIL reset_data: data=%h row=%0d col=%0d, expected 0", fm_data_in, fm_row, fm_col);
      end
      checks++;
      if (out_count !== '0 || timeout_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_status: out_count=%0d timeout_err=%b, expected 0", out_count, timeout_err);
      end
      rst = 1'b0;
   endtask

   task automatic test_basic_frame();
      run_frame(100, -1, NPIX, -1);
      checks++;
      if (fwd_cnt !== NPIX || done_cnt !== 1) begin
         errors++;
         $display("FAIL basic_counts: fwd=%0d done=%0d, expected %0d/1", fwd_cnt, done_cnt, NPIX);
      end
      checks++;
      if (done_cyc !== last_vo_cyc) begin
         errors++;
         $display("FAIL basic_done_timing: done at %0d, expected %0d", done_cyc, last_vo_cyc);
      end
      checks++;
      if (out_at_done !== OUTP || to_cyc !== -1) begin
         errors++;
         $display("FAIL basic_out_count: out_count=%0d to_cyc=%0d, expected %0d/-1", out_at_done, to_cyc, OUTP);
      end
   endtask

   task automatic test_backpressure();
      run_frame(100, 5, NPIX, -1);
      checks++;
      if (fwd_cnt !== NPIX || done_cnt !== 1 || out_at_done !== OUTP) begin
         errors++;
         $display("FAIL bp_counts: fwd=%0d done=%0d out=%0d, expected %0d/1/%0d",
                  fwd_cnt, done_cnt, out_at_done, NPIX, OUTP);
      end
   endtask

   task automatic test_bursty();
      run_frame(50, -1, NPIX, -1);
      checks++;
      if (fwd_cnt !== NPIX || done_cnt !== 1 || out_at_done !== OUTP) begin
         errors++;
         $display("FAIL bursty_counts: fwd=%0d done=%0d out=%0d, expected %0d/1/%0d",
                  fwd_cnt, done_cnt, out_at_done, NPIX, OUTP);
      end
   endtask

   task automatic test_timeout();
      run_frame(100, -1, NPIX - 2, -1);
      checks++;
      if (to_cyc !== last_vo_cyc + int'(TMO) || done_cyc !== to_cyc) begin
         errors++;
         $display("FAIL timeout_timing: timeout at %0d done at %0d, expected %0d",
                  to_cyc, done_cyc, last_vo_cyc + int'(TMO));
      end
      checks++;
      if (out_at_done !== OUTP - 2 || done_cnt !== 1) begin
         errors++;
         $display("FAIL timeout_counts: out=%0d done=%0d, expected %0d/1", out_at_done, done_cnt, OUTP - 2);
      end
      checks++;
      if (timeout_err !== 1'b1) begin
         errors++;
         $display("FAIL timeout_sticky: timeout_err=%b, expected 1", timeout_err);
      end
      run_frame(100, -1, NPIX, -1);
      checks++;
      if (to_cyc !== -1 || out_at_done !== OUTP) begin
         errors++;
         $display("FAIL timeout_recover: to_cyc=%0d out=%0d, expected -1/%0d", to_cyc, out_at_done, OUTP);
      end
   endtask

   task automatic test_reset_mid_frame();
      int acc;
      acc = 0;
      @(negedge clk);
      start = 1'b1; src_valid = 1'b1; sink_afull = 1'b0; fm_valid_out = 1'b0;
      for (int k = 0; k < 40 && acc < 7; k++) begin
         @(negedge clk);
         start = 1'b0;
         src_data = $urandom;
         #1;
         if (src_valid && src_ready === 1'b1) acc++;
      end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || fm_valid_in !== 1'b0 || done !== 1'b0 || src_ready !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid: busy=%b fm_valid_in=%b done=%b src_ready=%b, expected 0",
                  busy, fm_valid_in, done, src_ready);
      end
      checks++;
      if (out_count !== '0) begin
         errors++;
         $display("FAIL rst_mid_count: out_count=%0d, expected 0", out_count);
      end
      rst = 1'b0; src_valid = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         checks++;
         if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_idle: done=%b busy=%b, expected 0/0", done, busy);
         end
      end
      run_frame(100, -1, NPIX, -1);
      checks++;
      if (fwd_cnt !== NPIX || done_cnt !== 1 || out_at_done !== OUTP) begin
         errors++;
         $display("FAIL rst_recover: fwd=%0d done=%0d out=%0d, expected %0d/1/%0d",
                  fwd_cnt, done_cnt, out_at_done, NPIX, OUTP);
      end
   endtask

   task automatic test_ignored_start();
      run_frame(100, -1, NPIX, 6);
      checks++;
      if (fwd_cnt !== NPIX || done_cnt !== 1 || out_at_done !== OUTP) begin
         errors++;
         $display("FAIL ign_start: fwd=%0d done=%0d out=%0d, expected %0d/1/%0d",
                  fwd_cnt, done_cnt, out_at_done, NPIX, OUTP);
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL ign_start_idle: busy=%b, expected 0", busy);
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; src_valid = 1'b0; src_data = '0;
      sink_afull = 1'b0; fm_valid_out = 1'b0;
      test_reset();
      test_basic_frame();
      test_backpressure();
      test_bursty();
      test_timeout();
      test_reset_mid_frame();
      test_ignored_start();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
